// File: rtl/interval_timer_arbiter_pkg.sv
// interval_timer_arbiter_pkg: shared state encoding and default sizing for the interval timer arbiter.
package interval_timer_arbiter_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
   localparam int DEF_NREQ    = 4;
   localparam int DEF_PRE_W   = 14;
   localparam int DEF_PRE_DIV = 10000;
   localparam int DEF_CNT_W   = 14;
endpackage

// File: rtl/interval_timer_arbiter_if.sv
// interval_timer_arbiter_if: request/grant bundle between requesters (master) and the arbiter (slave).
interface interval_timer_arbiter_if
   import interval_timer_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int CNT_W = DEF_CNT_W
);
   logic [NREQ-1:0]       req;
   logic [NREQ*CNT_W-1:0] len;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic                  tick;
   modport master (output req, len, input gnt, done, busy, tick);
   modport slave  (input req, len, output gnt, done, busy, tick);
endinterface

// File: rtl/interval_timer_arbiter_tick_prescaler.sv
// tick_prescaler: divides clk by PRE_DIV into a one-cycle tick while enabled; clr restarts the phase.
module tick_prescaler
   import interval_timer_arbiter_pkg::*;
#(
   parameter int PRE_W   = DEF_PRE_W,
   parameter int PRE_DIV = DEF_PRE_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);
   logic [PRE_W-1:0] cnt_q, cnt_d;
   assign tick_o = en_i && (cnt_q == PRE_W'(PRE_DIV - 1));
   assign cnt_d  = (clr_i || tick_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter: round-robin grants of one shared prescaler; each grant times len ticks.
module interval_timer_arbiter
   import interval_timer_arbiter_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int PRE_W   = DEF_PRE_W,
   parameter int PRE_DIV = DEF_PRE_DIV,
   parameter int CNT_W   = DEF_CNT_W
) (
   input logic clk,
   input logic rst,
   interval_timer_arbiter_if.slave bus
);
   localparam int RW = $clog2(NREQ);
   state_e          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [RW-1:0]   rr_q, rr_d, win, idx;
   logic [CNT_W-1:0] left_q;
   logic            tick;
   // Descending scan so the first requester at or after rr_q wins.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = RW'((int'(rr_q) + i) % NREQ);
         if (bus.req[idx]) win = idx;
      end
   end
   assign rr_d = (win == RW'(NREQ - 1)) ? '0 : win + 1'b1;
   tick_prescaler #(.PRE_W(PRE_W), .PRE_DIV(PRE_DIV)) u_pre (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (state_q != S_RUN),
      .en_i   (state_q == S_RUN),
      .tick_o (tick)
   );
   // Abort is tested before the final tick so a dropped request never sees done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         left_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (|bus.req) begin
               state_q <= S_RUN;
               gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
               left_q  <= bus.len[win*CNT_W +: CNT_W];
               rr_q    <= rr_d;
            end
            S_RUN: if (!(|(bus.req & gnt_q))) begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
               left_q  <= '0;
            end else if (left_q == '0) begin
               state_q <= S_DONE;
            end else if (tick) begin
               left_q <= left_q - 1'b1;
               if (left_q == CNT_W'(1)) state_q <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end
   assign bus.gnt  = gnt_q;
   assign bus.done = gnt_q & {NREQ{state_q == S_DONE}};
   assign bus.busy = state_q != S_IDLE;
   assign bus.tick = tick;
endmodule
